// File: rtl/conv_share_arbiter.sv
// Shares one ConvUnit between NREQ requesters with round-robin grant.
// One convolution is in flight at a time, and its result goes back only to the requester that issued it.
module conv_share_arbiter #(
    parameter int NREQ   = 4,
    parameter int DATA_W = 64,
    parameter int KERN_W = 512,
    parameter int RES_W  = 128,
    parameter int CNT_W  = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ*DATA_W-1:0] req_data,
    input  logic [NREQ*KERN_W-1:0] req_kernel,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    output logic [RES_W-1:0]       resp_result,
    output logic [NREQ-1:0]        resp_valid,
    input  logic [NREQ-1:0]        resp_ready,
    output logic [DATA_W-1:0]      cu_in_data,
    output logic [KERN_W-1:0]      cu_kernel,
    output logic                   cu_in_valid,
    input  logic                   cu_in_ready,
    input  logic [RES_W-1:0]       cu_result,
    input  logic                   cu_out_valid,
    output logic                   cu_out_ready,
    output logic                   busy,
    output logic [CNT_W-1:0]       done_cnt
);
    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_BUSY, S_RESP} state_t;

    state_t             r_state;
    logic [IDX_W-1:0]   r_ptr;
    logic [IDX_W-1:0]   r_owner;
    logic [DATA_W-1:0]  r_cu_data;
    logic [KERN_W-1:0]  r_cu_kernel;
    logic               r_cu_in_valid;
    logic               r_cu_out_ready;
    logic [RES_W-1:0]   r_resp_result;
    logic [NREQ-1:0]    r_resp_valid;
    logic               r_busy;
    logic [CNT_W-1:0]   r_done_cnt;

    logic [DATA_W-1:0]  w_data   [NREQ];
    logic [KERN_W-1:0]  w_kernel [NREQ];
    logic [IDX_W-1:0]   w_idx;
    logic [IDX_W-1:0]   w_grant;
    logic               w_any;
    logic [NREQ-1:0]    w_grant_oh;
    logic [NREQ-1:0]    w_owner_oh;

    for (genvar i = 0; i < NREQ; i++) begin : g_slot
        assign w_data[i]   = req_data[i*DATA_W +: DATA_W];
        assign w_kernel[i] = req_kernel[i*KERN_W +: KERN_W];
    end

    // Search starts just after the last-served requester, so that one ends up lowest priority.
    always_comb begin
        // NOTE: every always_comb target gets a default first, so no path can infer a latch.
        w_idx   = '0;
        w_grant = r_ptr;
        w_any   = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            w_idx = IDX_W'((int'(r_ptr) + k) % NREQ);
            if (!w_any && req_valid[w_idx]) begin
                w_grant = w_idx;
                w_any   = 1'b1;
            end
        end
    end

    always_comb begin
        w_grant_oh = '0;
        if (w_any) begin
            w_grant_oh[w_grant] = 1'b1;
        end
        w_owner_oh = '0;
        w_owner_oh[r_owner] = 1'b1;
    end

    // The grant is recomputed every cycle; nothing is held for a requester that drops valid.
    assign req_ready    = (r_state == S_IDLE) ? w_grant_oh : '0;
    assign cu_in_data   = r_cu_data;
    assign cu_kernel    = r_cu_kernel;
    assign cu_in_valid  = r_cu_in_valid;
    assign cu_out_ready = r_cu_out_ready;
    assign resp_result  = r_resp_result;
    assign resp_valid   = r_resp_valid;
    assign busy         = r_busy;
    assign done_cnt     = r_done_cnt;

    // NOTE: sequential state uses non-blocking assignments only, so each register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            // The wide data and result registers are cleared as well: every output reads 0 after reset.
            r_state        <= S_IDLE;
            r_ptr          <= IDX_W'(NREQ - 1);
            r_owner        <= '0;
            r_cu_data      <= '0;
            r_cu_kernel    <= '0;
            r_cu_in_valid  <= 1'b0;
            r_cu_out_ready <= 1'b0;
            r_resp_result  <= '0;
            r_resp_valid   <= '0;
            r_busy         <= 1'b0;
            r_done_cnt     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_cu_data     <= w_data[w_grant];
                        r_cu_kernel   <= w_kernel[w_grant];
                        r_owner       <= w_grant;
                        r_cu_in_valid <= 1'b1;
                        r_busy        <= 1'b1;
                        r_state       <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (cu_in_ready) begin
                        r_cu_in_valid  <= 1'b0;
                        r_cu_out_ready <= 1'b1;
                        r_state        <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (cu_out_valid) begin
                        r_resp_result  <= cu_result;
                        r_cu_out_ready <= 1'b0;
                        r_resp_valid   <= w_owner_oh;
                        r_state        <= S_RESP;
                    end
                end
                S_RESP: begin
                    // Only the owner's resp_ready can retire the result.
                    if (resp_ready[r_owner]) begin
                        r_resp_valid <= '0;
                        r_ptr        <= r_owner;
                        r_done_cnt   <= r_done_cnt + 1'b1;
                        r_busy       <= 1'b0;
                        r_state      <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_conv_share_arbiter.sv
// Self-checking bench for conv_share_arbiter: a behavioural ConvUnit, a table of grant scenarios,
// and an expected-result queue that is filled at each grant and drained at each response.
module tb_conv_share_arbiter;
    localparam int NREQ   = 4;
    localparam int DATA_W = 64;
    localparam int KERN_W = 512;
    localparam int RES_W  = 128;
    localparam int CNT_W  = 4;   // narrow counter so the wrap to zero is reached in a short run

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic [NREQ*DATA_W-1:0] req_data;
    logic [NREQ*KERN_W-1:0] req_kernel;
    logic [NREQ-1:0]        req_valid  = '0;
    logic [NREQ-1:0]        req_ready;
    logic [RES_W-1:0]       resp_result;
    logic [NREQ-1:0]        resp_valid;
    logic [NREQ-1:0]        resp_ready = '0;
    logic [DATA_W-1:0]      cu_in_data;
    logic [KERN_W-1:0]      cu_kernel;
    logic                   cu_in_valid;
    logic                   cu_in_ready;
    logic [RES_W-1:0]       cu_result;
    logic                   cu_out_valid;
    logic                   cu_out_ready;
    logic                   busy;
    logic [CNT_W-1:0]       done_cnt;

    conv_share_arbiter #(
        .NREQ(NREQ), .DATA_W(DATA_W), .KERN_W(KERN_W), .RES_W(RES_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst),
        .req_data(req_data), .req_kernel(req_kernel),
        .req_valid(req_valid), .req_ready(req_ready),
        .resp_result(resp_result), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .cu_in_data(cu_in_data), .cu_kernel(cu_kernel),
        .cu_in_valid(cu_in_valid), .cu_in_ready(cu_in_ready),
        .cu_result(cu_result), .cu_out_valid(cu_out_valid), .cu_out_ready(cu_out_ready),
        .busy(busy), .done_cnt(done_cnt)
    );

    always #5 clk = ~clk;

    // Stand-in for the ConvUnit arithmetic: 8 data bytes dotted with 8 kernel words.
    function automatic logic [RES_W-1:0] golden(input logic [DATA_W-1:0] d, input logic [KERN_W-1:0] k);
        logic [RES_W-1:0] acc;
        acc = '0;
        for (int i = 0; i < 8; i++) begin
            acc = acc + RES_W'(d[i*8 +: 8]) * RES_W'(k[i*64 +: 64]);
        end
        return acc;
    endfunction

    function automatic int rr_pick(input int ptr, input logic [NREQ-1:0] mask);
        for (int k = 1; k <= NREQ; k++) begin
            if (mask[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        end
        return -1;
    endfunction

    // Per-requester stimulus data
    logic [DATA_W-1:0] d_slot [NREQ];
    logic [KERN_W-1:0] k_slot [NREQ];

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            req_data[i*DATA_W +: DATA_W]   = d_slot[i];
            req_kernel[i*KERN_W +: KERN_W] = k_slot[i];
        end
    end

    // Behavioural ConvUnit with adjustable accept delay and compute latency
    int               cu_acc = 0;
    int               cu_lat = 0;
    int               cu_wait;
    int               cu_cnt;
    logic [1:0]       cu_st;
    logic             cu_ov_r;
    logic [RES_W-1:0] cu_res_r;
    logic             cu_spur = 1'b0;
    logic [RES_W-1:0] cu_spur_res = '0;

    assign cu_in_ready  = (cu_st == 2'd0) && (cu_wait >= cu_acc) && !rst;
    assign cu_out_valid = cu_ov_r | cu_spur;
    assign cu_result    = cu_spur ? cu_spur_res : cu_res_r;

    always @(posedge clk) begin
        if (rst) begin
            cu_st <= 2'd0; cu_wait <= 0; cu_cnt <= 0; cu_ov_r <= 1'b0; cu_res_r <= '0;
        end else begin
            case (cu_st)
                2'd0: begin
                    if (cu_in_valid && cu_in_ready) begin
                        cu_res_r <= golden(cu_in_data, cu_kernel);
                        cu_cnt   <= cu_lat;
                        cu_wait  <= 0;
                        cu_st    <= 2'd1;
                    end else if (cu_in_valid) begin
                        cu_wait <= cu_wait + 1;
                    end else begin
                        cu_wait <= 0;
                    end
                end
                2'd1: begin
                    if (cu_cnt == 0) begin
                        cu_ov_r <= 1'b1;
                        cu_st   <= 2'd2;
                    end else begin
                        cu_cnt <= cu_cnt - 1;
                    end
                end
                default: begin
                    if (cu_ov_r && cu_out_ready) begin
                        cu_ov_r <= 1'b0;
                        cu_st   <= 2'd0;
                    end
                end
            endcase
        end
    end

    // Scoreboard
    typedef struct {
        int               owner;
        logic [RES_W-1:0] res;
    } exp_t;

    exp_t             sb[$];
    int               n_checks = 0;
    int               n_errors = 0;
    int               exp_cnt  = 0;
    int               m_ptr    = NREQ - 1;
    logic [RES_W-1:0] last_res = '0;

    task automatic check(input string name, input logic [KERN_W-1:0] act, input logic [KERN_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_req_ready"},    req_ready,    0);
        check({tag, "_resp_valid"},   resp_valid,   0);
        check({tag, "_resp_result"},  resp_result,  0);
        check({tag, "_cu_in_valid"},  cu_in_valid,  0);
        check({tag, "_cu_out_ready"}, cu_out_ready, 0);
        check({tag, "_cu_in_data"},   cu_in_data,   0);
        check({tag, "_cu_kernel"},    cu_kernel,    0);
        check({tag, "_busy"},         busy,         0);
        check({tag, "_done_cnt"},     done_cnt,     0);
    endtask

    task automatic randomize_slots();
        for (int i = 0; i < NREQ; i++) begin
            d_slot[i] = {$urandom, $urandom};
            for (int j = 0; j < KERN_W / 32; j++) k_slot[i][j*32 +: 32] = $urandom;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; req_valid = '0; resp_ready = '0;
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        sb.delete();
        exp_cnt = 0; m_ptr = NREQ - 1; last_res = '0;
    endtask

    // One full transaction, entered and left on a negedge with the DUT idle.
    task automatic run_txn(input logic [NREQ-1:0] mask, input int g, input int hold,
                           input int acc, input int lat);
        exp_t            e;
        logic [NREQ-1:0] oh;
        int              n;
        bit              prev_hs;
        oh = '0; oh[g] = 1'b1;
        randomize_slots();
        cu_acc = acc; cu_lat = lat;
        req_valid = mask;
        #1;
        check("req_ready_grant", req_ready, oh);
        e.owner = g; e.res = golden(d_slot[g], k_slot[g]);
        sb.push_back(e);
        @(posedge clk); @(negedge clk);
        check("cu_in_valid_next", cu_in_valid, 1);
        check("cu_out_ready_issue", cu_out_ready, 0);
        check("req_ready_after_hs", req_ready, 0);
        check("busy_after_hs", busy, 1);
        check("cu_in_data", cu_in_data, d_slot[g]);
        check("cu_kernel", cu_kernel, k_slot[g]);
        n = 0; prev_hs = 1'b0;
        while (resp_valid == '0 && n < 200) begin
            prev_hs = cu_out_valid && cu_out_ready;
            @(negedge clk); n++;
        end
        if (resp_valid == '0) begin
            check("resp_timeout", resp_valid, oh);
            req_valid = '0;
            return;
        end
        check("resp_latency", prev_hs, 1);
        for (int h = 0; h < hold; h++) begin
            resp_ready = ~oh;
            @(negedge clk);
            check("hold_resp_valid", resp_valid, oh);
            check("hold_resp_result", resp_result, sb[0].res);
            check("hold_req_ready", req_ready, 0);
            check("hold_cu_in_valid", cu_in_valid, 0);
        end
        resp_ready = oh;
        e = sb.pop_front();
        check("resp_valid_owner", resp_valid, 1 << e.owner);
        check("resp_result", resp_result, e.res);
        last_res = e.res;
        req_valid = '0;
        @(posedge clk); @(negedge clk);
        resp_ready = '0;
        exp_cnt++;
        check("done_cnt", done_cnt, exp_cnt % (1 << CNT_W));
        check("busy_idle", busy, 0);
        check("resp_valid_clear", resp_valid, 0);
        m_ptr = g;
    endtask

    typedef struct {
        logic [NREQ-1:0] mask;
        int              grant;
        int              hold;
        int              acc;
        int              lat;
    } vec_t;

    vec_t tbl[9];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        logic [NREQ-1:0] m;
        int              g;

        // all four requesters from reset, then 2 alone, then 1 and 3 together, then a stalled response
        tbl[0] = '{4'b1111, 0, 0, 0, 0};
        tbl[1] = '{4'b1111, 1, 1, 1, 2};
        tbl[2] = '{4'b1111, 2, 0, 0, 1};
        tbl[3] = '{4'b1111, 3, 2, 2, 0};
        tbl[4] = '{4'b1111, 0, 0, 0, 3};
        tbl[5] = '{4'b0100, 2, 0, 0, 0};
        tbl[6] = '{4'b1010, 3, 0, 1, 1};
        tbl[7] = '{4'b1010, 1, 0, 0, 0};
        tbl[8] = '{4'b0001, 0, 10, 0, 2};

        randomize_slots();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_reset_state("reset");

        // single request from requester 0
        run_txn(4'b0001, 0, 0, 0, 0);
        check("single_done_cnt", done_cnt, 1);

        do_reset();
        for (int i = 0; i < 9; i++) begin
            run_txn(tbl[i].mask, tbl[i].grant, tbl[i].hold, tbl[i].acc, tbl[i].lat);
            if (i == 4) check("rr_done_cnt", done_cnt, 5);
        end

        // a stray cu_out_valid while idle must not be captured
        cu_spur_res = {4{32'hDEADBEEF}};
        cu_spur = 1'b1;
        @(posedge clk); @(negedge clk);
        cu_spur = 1'b0;
        check("spur_resp_valid", resp_valid, 0);
        check("spur_busy", busy, 0);
        check("spur_resp_result", resp_result, last_res);
        check("spur_done_cnt", done_cnt, exp_cnt % (1 << CNT_W));

        // reset while the ConvUnit is computing
        randomize_slots();
        cu_acc = 0; cu_lat = 8;
        req_valid = 4'b0100;
        #1;
        check("rstbusy_grant", req_ready, 4'b0100);
        @(posedge clk); @(negedge clk);
        req_valid = '0;
        @(posedge clk); @(negedge clk);
        check("rstbusy_in_busy", cu_out_ready, 1);
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        check_reset_state("midrst");
        rst = 1'b0;
        sb.delete();
        exp_cnt = 0; m_ptr = NREQ - 1; last_res = '0;
        @(negedge clk);
        run_txn(4'b1111, 0, 0, 0, 1);

        // random traffic until the counter wraps past all-ones
        while (exp_cnt < (1 << CNT_W)) begin
            m = 4'($urandom_range(1, 15));
            g = rr_pick(m_ptr, m);
            run_txn(m, g, $urandom_range(0, 2), $urandom_range(0, 1), $urandom_range(0, 3));
        end
        check("wrap_done_cnt", done_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
